// File: rtl/sdram_host_arbiter_pkg.sv
// Purpose: shared widths, FSM encoding and helpers for the SDRAM host-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ADDR_W/LEN_W/DATA_W bus widths, 12-bit watchdog width, arbiter state enum,
//           idx_w() helper giving the port-index width for a given port count.
package sdram_host_arbiter_pkg;

    localparam int ADDR_W = 23;
    localparam int LEN_W  = 9;
    localparam int DATA_W = 16;
    localparam int WDOG_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Index width for n ports; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Purpose: bus bundles for the arbiter - client side (per-port packed vectors) and controller side.
// Latency: n/a (wiring only).
// Backpressure: clients hold P_WR/P_RD until P_DONE; controller paces data with IN_REQ/OUT_VALID.
// sdram_host_arbiter_if : P_WR/P_RD/P_ADDR/P_LENGTH/P_DATAIN from clients, P_GNT/P_IN_REQ/
//                         P_OUT_VALID/P_DONE/P_DATAOUT back to them. master = clients, slave = arbiter.
// sdram_host_ctrl_if    : ADDR/LENGTH/WR/RD/DATAIN to the controller, DONE/IN_REQ/OUT_VALID/DATAOUT
//                         from it. master = arbiter, slave = controller.
interface sdram_host_arbiter_if
    import sdram_host_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]        P_WR;
    logic [NUM_PORTS-1:0]        P_RD;
    logic [NUM_PORTS*ADDR_W-1:0] P_ADDR;
    logic [NUM_PORTS*LEN_W-1:0]  P_LENGTH;
    logic [NUM_PORTS*DATA_W-1:0] P_DATAIN;
    logic [NUM_PORTS-1:0]        P_GNT;
    logic [NUM_PORTS-1:0]        P_IN_REQ;
    logic [NUM_PORTS-1:0]        P_OUT_VALID;
    logic [NUM_PORTS-1:0]        P_DONE;
    logic [DATA_W-1:0]           P_DATAOUT;

    modport master (
        output P_WR, P_RD, P_ADDR, P_LENGTH, P_DATAIN,
        input  P_GNT, P_IN_REQ, P_OUT_VALID, P_DONE, P_DATAOUT
    );

    modport slave (
        input  P_WR, P_RD, P_ADDR, P_LENGTH, P_DATAIN,
        output P_GNT, P_IN_REQ, P_OUT_VALID, P_DONE, P_DATAOUT
    );
endinterface

interface sdram_host_ctrl_if
    import sdram_host_arbiter_pkg::*;
;
    logic [ADDR_W-1:0] ADDR;
    logic [LEN_W-1:0]  LENGTH;
    logic              WR;
    logic              RD;
    logic [DATA_W-1:0] DATAIN;
    logic              DONE;
    logic              IN_REQ;
    logic              OUT_VALID;
    logic [DATA_W-1:0] DATAOUT;

    modport master (
        output ADDR, LENGTH, WR, RD, DATAIN,
        input  DONE, IN_REQ, OUT_VALID, DATAOUT
    );

    modport slave (
        input  ADDR, LENGTH, WR, RD, DATAIN,
        output DONE, IN_REQ, OUT_VALID, DATAOUT
    );
endinterface

// File: rtl/sdram_host_arbiter_rr_picker.sv
// Purpose: round-robin winner select - first requesting port after i_last, searched cyclically.
// Latency: combinational.
// Backpressure: none; o_vld is low when no port requests.
// Ports: i_req (per-port request), i_last (index of last served port),
//        o_gnt (one-hot winner), o_idx (winner index), o_vld (any request present).
module sdram_host_arbiter_rr_picker
    import sdram_host_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [NUM_PORTS-1:0] o_gnt,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_vld
);

    always_comb begin
        int  cand;
        logic found;
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = 0;
        // Offset 1 first so the last-served port is checked last (lowest priority).
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = (int'(i_last) + off) % NUM_PORTS;
            if (!found && i_req[cand]) begin
                found       = 1'b1;
                o_gnt[cand] = 1'b1;
                o_idx       = IDX_W'(cand);
            end
        end
        o_vld = found;
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Purpose: shares one Sdram_Controller host port among NUM_PORTS clients, round-robin, one burst per grant.
// Latency: request sampled at edge k -> WR/RD high after edge k; DONE at edge d -> next WR/RD after edge d+2.
// Backpressure: clients hold requests until P_DONE; a burst without DONE is aborted after TIMEOUT cycles.
// Ports: CLK, RESET_N (async, active-low); client (per-port requests/grants/data routing);
//        ctrl (registered ADDR/LENGTH/WR/RD, muxed DATAIN, DONE/IN_REQ/OUT_VALID/DATAOUT);
//        ERR (sticky watchdog-abort flag, cleared only by reset).
module sdram_host_arbiter
    import sdram_host_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    sdram_host_arbiter_if.slave  client,
    sdram_host_ctrl_if.master    ctrl,
    output logic                 ERR
);

    localparam int IDX_W = idx_w(NUM_PORTS);
    // Watchdog is 12 bits wide, so TIMEOUT is meaningful up to 4096.
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [NUM_PORTS-1:0] r_pdone;
    logic                 r_wr;
    logic                 r_rd;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W-1:0]     r_len;
    logic [WDOG_W-1:0]    r_wdog;
    logic                 r_err;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_win_oh;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_vld;
    logic [DATA_W-1:0]    w_datain;

    assign w_req = client.P_WR | client.P_RD;

    sdram_host_arbiter_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_req  (w_req),
        .i_last (r_last),
        .o_gnt  (w_win_oh),
        .o_idx  (w_win_idx),
        .o_vld  (w_win_vld)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_last  <= IDX_W'(NUM_PORTS - 1);
            r_idx   <= '0;
            r_gnt   <= '0;
            r_pdone <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_wdog  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pdone <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_state <= ST_BUSY;
                        r_gnt   <= w_win_oh;
                        r_idx   <= w_win_idx;
                        r_addr  <= client.P_ADDR[w_win_idx*ADDR_W +: ADDR_W];
                        r_len   <= client.P_LENGTH[w_win_idx*LEN_W +: LEN_W];
                        // Both bits set selects a write.
                        r_wr    <= client.P_WR[w_win_idx];
                        r_rd    <= ~client.P_WR[w_win_idx];
                        r_wdog  <= '0;
                    end
                end
                ST_BUSY: begin
                    if (ctrl.DONE || (r_wdog == WDOG_MAX)) begin
                        r_wr    <= 1'b0;
                        r_rd    <= 1'b0;
                        r_pdone <= r_gnt;
                        // An aborted burst still counts as served, so a hung port
                        // cannot keep top priority.
                        r_last  <= r_idx;
                        r_state <= ST_GAP;
                        if (!ctrl.DONE) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                ST_GAP: begin
                    // One cycle with WR=RD=0 so the controller sees the request drop.
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_datain = '0;
        if (|r_gnt) begin
            w_datain = client.P_DATAIN[r_idx*DATA_W +: DATA_W];
        end
    end

    assign ctrl.ADDR          = r_addr;
    assign ctrl.LENGTH        = r_len;
    assign ctrl.WR            = r_wr;
    assign ctrl.RD            = r_rd;
    assign ctrl.DATAIN        = w_datain;

    assign client.P_GNT       = r_gnt;
    assign client.P_DONE      = r_pdone;
    assign client.P_IN_REQ    = r_gnt & {NUM_PORTS{ctrl.IN_REQ}};
    assign client.P_OUT_VALID = r_gnt & {NUM_PORTS{ctrl.OUT_VALID}};
    assign client.P_DATAOUT   = ctrl.DATAOUT;

    assign ERR = r_err;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Purpose: directed self-checking bench for sdram_host_arbiter with an expected-grant scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_host_arbiter;
    import sdram_host_arbiter_pkg::*;

    localparam int NP         = 4;
    localparam int TB_TIMEOUT = 4096;

    typedef struct {
        int               port;
        bit               wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } exp_t;

    logic clk;
    logic rst_n;
    logic err;
    int   n_chk;
    int   n_err;
    exp_t q[$];

    sdram_host_arbiter_if #(.NUM_PORTS(NP)) cif();
    sdram_host_ctrl_if                     cti();

    sdram_host_arbiter #(
        .NUM_PORTS (NP),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .client  (cif.slave),
        .ctrl    (cti.master),
        .ERR     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise a request for port p and record the burst the DUT should issue for it.
    task automatic request(input int p, input bit wr, input bit rd,
                           input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        exp_t e;
        cif.P_WR[p] = wr;
        cif.P_RD[p] = rd;
        cif.P_ADDR[p*ADDR_W +: ADDR_W] = a;
        cif.P_LENGTH[p*LEN_W +: LEN_W] = l;
        e.port = p;
        e.wr   = wr;
        e.addr = a;
        e.len  = l;
        q.push_back(e);
    endtask

    task automatic drop(input int p);
        cif.P_WR[p] = 1'b0;
        cif.P_RD[p] = 1'b0;
    endtask

    task automatic do_reset();
        cif.P_WR = '0;
        cif.P_RD = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Controller model: waits for the next burst, compares it against the scoreboard head,
    // runs data_cycles of handshaking, then ends it with DONE (or lets the watchdog fire).
    // Returns at the negedge after the GAP edge; 'waited' is negedges until WR/RD was seen.
    task automatic serve(input int data_cycles, input bit no_done, input bit drop_mid,
                         output int waited);
        exp_t       e;
        int         cnt;
        logic [3:0] oh;
        waited = 0;
        while (!(cti.WR || cti.RD) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (!(cti.WR || cti.RD)) begin
            chk("grant_seen", {31'b0, cti.WR | cti.RD}, 32'd1);
            return;
        end
        if (q.size() == 0) begin
            chk("sb_nonempty", 32'(q.size()), 32'd1);
            return;
        end
        e  = q.pop_front();
        oh = 4'(1 << e.port);
        chk("gnt",    32'(cif.P_GNT), 32'(oh));
        chk("wr",     32'(cti.WR),    32'(e.wr));
        chk("rd",     32'(cti.RD),    32'(!e.wr));
        chk("addr",   32'(cti.ADDR),  32'(e.addr));
        chk("length", 32'(cti.LENGTH), 32'(e.len));
        for (int i = 0; i < data_cycles; i++) begin
            cti.OUT_VALID = !e.wr;
            cti.IN_REQ    = e.wr;
            cti.DATAOUT   = 16'h5A00 + 16'(i);
            if (drop_mid && i == 1) drop(e.port);
            #1;
            chk("out_valid_route", 32'(cif.P_OUT_VALID), e.wr ? 32'd0 : 32'(oh));
            chk("in_req_route",    32'(cif.P_IN_REQ),    e.wr ? 32'(oh) : 32'd0);
            chk("datain_mux",      32'(cti.DATAIN),      32'h0000A000 + 32'(e.port));
            chk("dataout_bcast",   32'(cif.P_DATAOUT),   32'h00005A00 + 32'(i));
            @(negedge clk);
            chk("op_hold", 32'({cti.WR, cti.RD}), 32'({e.wr, !e.wr}));
        end
        cti.OUT_VALID = 1'b0;
        cti.IN_REQ    = 1'b0;
        if (no_done) begin
            cnt = 0;
            while ((cti.WR || cti.RD) && cnt < TB_TIMEOUT + 16) begin
                cnt++;
                @(negedge clk);
            end
            chk("timeout_len", 32'(cnt), 32'(TB_TIMEOUT));
            chk("err_set",     32'(err), 32'd1);
        end else begin
            cti.DONE = 1'b1;
            @(negedge clk);
            cti.DONE = 1'b0;
            chk("op_clear", 32'({cti.WR, cti.RD}), 32'd0);
        end
        chk("pdone",       32'(cif.P_DONE), 32'(oh));
        chk("gnt_in_gap",  32'(cif.P_GNT),  32'(oh));
        @(negedge clk);
        chk("pdone_pulse", 32'(cif.P_DONE), 32'd0);
        chk("gnt_clear",   32'(cif.P_GNT),  32'd0);
        chk("gap_idle",    32'({cti.WR, cti.RD}), 32'd0);
    endtask

    initial begin
        int w;
        int n;
        n_chk = 0;
        n_err = 0;
        cif.P_WR      = '0;
        cif.P_RD      = '0;
        cif.P_ADDR    = '0;
        cif.P_LENGTH  = '0;
        cif.P_DATAIN  = 64'hA003_A002_A001_A000;
        cti.DONE      = 1'b0;
        cti.IN_REQ    = 1'b0;
        cti.OUT_VALID = 1'b0;
        cti.DATAOUT   = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_wr",     32'(cti.WR),     32'd0);
        chk("rst_rd",     32'(cti.RD),     32'd0);
        chk("rst_gnt",    32'(cif.P_GNT),  32'd0);
        chk("rst_pdone",  32'(cif.P_DONE), 32'd0);
        chk("rst_err",    32'(err),        32'd0);
        chk("rst_addr",   32'(cti.ADDR),   32'd0);
        chk("rst_len",    32'(cti.LENGTH), 32'd0);
        chk("rst_datain", 32'(cti.DATAIN), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single port write: WR visible one cycle after the request
        request(0, 1'b1, 1'b0, 23'h000010, 9'h080);
        serve(3, 1'b0, 1'b0, w);
        chk("t1_latency", 32'(w), 32'd1);
        drop(0);

        // Contention from reset: 0 then 2; second RD two cycles after DONE edge
        do_reset();
        request(0, 1'b0, 1'b1, 23'h000100, 9'h004);
        request(2, 1'b0, 1'b1, 23'h000200, 9'h008);
        serve(2, 1'b0, 1'b0, w);
        drop(0);
        serve(2, 1'b0, 1'b0, w);
        chk("t2_gap", 32'(w), 32'd1);
        drop(2);

        // All ports continuously requesting: 0,1,2,3,0,1,2,3
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                request(p, (p % 2) == 0, (p % 2) == 1, 23'(23'h010000 * (p + 1)), 9'(16 + p));
            end
        end
        for (int b = 0; b < 8; b++) begin
            serve(2, 1'b0, 1'b0, w);
            chk("t3_gap", 32'(w), 32'd1);
        end
        for (int p = 0; p < NP; p++) drop(p);

        // Port 1 with WR and RD together; drops both mid-burst
        request(1, 1'b1, 1'b1, 23'h7FFFFF, 9'h1FF);
        serve(3, 1'b0, 1'b1, w);
        chk("t4_err_clear", 32'(err), 32'd0);

        // Watchdog abort, then a normal burst with ERR sticky
        request(3, 1'b0, 1'b1, 23'h123456, 9'h0AA);
        serve(0, 1'b1, 1'b0, w);
        drop(3);
        request(2, 1'b1, 1'b0, 23'h000ABC, 9'h011);
        serve(2, 1'b0, 1'b0, w);
        drop(2);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset mid-burst clears outputs asynchronously; port 0 first afterwards
        cif.P_WR[3] = 1'b1;
        cif.P_ADDR[3*ADDR_W +: ADDR_W] = 23'h000333;
        n = 0;
        while (!cti.WR && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("t6_busy", 32'(cti.WR), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr",  32'(cti.WR),    32'd0);
        chk("t6_rst_rd",  32'(cti.RD),    32'd0);
        chk("t6_rst_gnt", 32'(cif.P_GNT), 32'd0);
        chk("t6_rst_err", 32'(err),       32'd0);
        q.delete();
        cif.P_WR[3] = 1'b0;
        request(0, 1'b1, 1'b0, 23'h000001, 9'h002);
        request(2, 1'b0, 1'b1, 23'h000002, 9'h003);
        request(3, 1'b1, 1'b0, 23'h000333, 9'h011);
        @(negedge clk);
        rst_n = 1'b1;
        serve(1, 1'b0, 1'b0, w);
        drop(0);
        serve(1, 1'b0, 1'b0, w);
        drop(2);
        serve(1, 1'b0, 1'b0, w);
        drop(3);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
